pc_result_serializer: RTL and testbench
=======================================

Name: pc_result_serializer

Overview:
- Initiator and consumer for the polynomial-check (PC) start/done interface in the sign datapath.
- On a request from the sign controller, it pulses start to the PC unit and waits for the PC unit's done pulse.
- On done, it captures the alpha/beta/v result vectors and streams them as 32-bit words over a valid/ready interface to the hash absorb stage.
- Works with the real PC core and with the cycle-count-accurate PC stand-in.

Parameters:
- FIELD, "GF256", field selector ("GF256" or "P251"); passed through for config consistency, no datapath effect.
- PARAMETER_SET, "L1", security level ("L1", "L3" or "L5").
- T, 4 if PARAMETER_SET=="L5" else 3, number of 32-bit words per result vector.
- TIMEOUT_CYCLES, 200000, maximum wait for PC done; used only with PC_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  request from sign controller; sampled only in s_idle
- o_busy  out  1  high in every state except s_idle
- o_done  out  1  one-cycle pulse after the last word is accepted
- o_timeout  out  1  one-cycle pulse on PC timeout; constant 0 without PC_TIMEOUT_EN
- o_pc_start  out  1  one-cycle start pulse to PC unit
- i_pc_done  in  1  done pulse from PC unit
- i_alpha  in  32*T  PC alpha result
- i_beta  in  32*T  PC beta result
- i_v  in  32*T  PC v result
- o_data  out  32  stream word
- o_data_valid  out  1  o_data is valid
- i_data_ready  in  1  downstream accepts the word

Behaviour:
- Reset: all outputs are 0 and the state is s_idle. Word counter, capture register (96*T bits) and timeout counter are cleared. Reset has priority in every state, including mid-stream.
- States: s_idle, s_req, s_wait, s_stream, s_fin.
- s_idle:
  - On i_start=1, go to s_req.
  - i_pc_done is ignored.
- s_req:
  - o_pc_start=1 for exactly this one cycle, then go to s_wait.
  - Latency: i_start sampled at edge N, o_pc_start high during cycle N+1.
- s_wait:
  - Hold until i_pc_done=1.
  - On that edge, capture {i_v, i_beta, i_alpha} and clear the word counter. go to s_stream.
  - o_data_valid rises in the next cycle.
- s_stream:
  - o_data_valid=1.
  - o_data = captured word[idx], idx 0..3T-1.
  - Word order: alpha[31:0] first, then alpha next-higher 32-bit slices, then beta, then v. Word k of a vector is bits [32k+31:32k].
  - Transfer occurs when o_data_valid && i_data_ready.
  - On a transfer with idx<3T-1, idx increments and the next word is presented the following cycle.
  - On a transfer with idx==3T-1, go to s_fin.
  - With i_data_ready=0, o_data and o_data_valid hold stable. No word is dropped or duplicated.
  - Back-to-back ready gives one word per cycle: 3T cycles minimum.
- s_fin: o_done=1 for one cycle, then go to s_idle. o_data_valid=0.
- i_start in any non-idle state is ignored; no queuing.
- i_pc_done outside s_wait is ignored; no capture.
- Capture register is written only on the s_wait done edge. Input changes after capture do not affect the stream.
- Word counter width is clog2(3T)+1. No wrap-around is possible, since it is reset each capture.
- o_busy rises the cycle after i_start is accepted and falls in the cycle after o_done.

Optional Feature:
- Macro PC_TIMEOUT_EN.
- Defined:
  - A counter runs in s_wait.
  - If it reaches TIMEOUT_CYCLES-1 without i_pc_done, o_timeout pulses 1 cycle, the state returns to s_idle, and no data is streamed and no o_done is issued.
  - i_pc_done arriving on the same edge as expiry wins: normal capture, no timeout.
- Undefined: no counter, s_wait waits indefinitely, and o_timeout is tied to 0.

Test Plan:
- Basic: T=3, alpha={32'h33333333,32'h22222222,32'h11111111}, beta 0x44..-0x66.., v 0x77..-0x99.., i_data_ready=1, done 50 cycles after o_pc_start -> o_pc_start 1 cycle; 9 words 0x11111111..0x99999999 in order on consecutive cycles; o_done 1 cycle after the last word.
- Backpressure: same vectors, i_data_ready toggled 1-0-0-1 repeatedly -> each word held stable while ready=0; exactly 9 transfers; no repeats.
- Spurious inputs: i_pc_done pulsed in s_idle, i_start pulsed during s_stream -> no capture, no extra o_pc_start, stream unaffected.
- L5: PARAMETER_SET="L5" (T=4), alpha words 0x0A000000+k -> 12 words; word 3 = 0x0A000003, word 4 = beta word 0.
- Reset mid-stream: assert i_rst after word 4 accepted -> next cycle all outputs 0 and the state is s_idle. A new i_start gives a full 9-word stream from word 0.
- Timeout (PC_TIMEOUT_EN, TIMEOUT_CYCLES=100): no i_pc_done -> o_timeout pulse 100 cycles after entering s_wait, no o_data_valid, o_busy=0 afterwards. Done on the expiry edge -> normal stream, o_timeout stays 0.

Source files
------------

// File: rtl/pc_result_serializer.sv
// rtl/pc_result_serializer.sv - PC start/done initiator and result word serializer
//
// Pulses start to the polynomial-check unit on request, waits for its done
// pulse, captures {v, beta, alpha} and streams the capture as 32-bit words,
// alpha word 0 first, over a valid/ready interface.
//
// Optional macro: PC_TIMEOUT_EN adds a bounded wait for PC done (TIMEOUT_CYCLES).
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start               request from sign controller (honoured only when idle)
//   o_busy                high whenever not idle
//   o_done                one-cycle pulse after the last word is accepted
//   o_timeout             one-cycle pulse when the PC wait expires
//   o_pc_start            one-cycle start pulse to the PC unit
//   i_pc_done             done pulse from the PC unit
//   i_alpha/i_beta/i_v    PC result vectors, 32*T bits each
//   o_data/o_data_valid   stream word and its valid
//   i_data_ready          downstream accepts the word

module pc_result_serializer #(
    parameter        FIELD          = "GF256",
    parameter        PARAMETER_SET  = "L1",
    parameter int    T              = (PARAMETER_SET == "L5") ? 4 : 3,
    parameter int    TIMEOUT_CYCLES = 200000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_timeout,
    output logic              o_pc_start,
    input  logic              i_pc_done,
    input  logic [32*T-1:0]   i_alpha,
    input  logic [32*T-1:0]   i_beta,
    input  logic [32*T-1:0]   i_v,
    output logic [31:0]       o_data,
    output logic              o_data_valid,
    input  logic              i_data_ready
);

    localparam int NWORDS = 3 * T;
    localparam int CW     = $clog2(NWORDS) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);

    // Configuration sanity: the field selector has no datapath effect, but a
    // mistyped value should stop elaboration rather than pass silently.
    if ((FIELD != "GF256" && FIELD != "P251") || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("pc_result_serializer: bad FIELD or TIMEOUT_CYCLES");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_STREAM,
        S_FIN
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          idx_q, idx_d;
    logic [96*T-1:0]        cap_q, cap_d;
    logic                   tmo_hit;

`ifdef PC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0]          tmo_q, tmo_d;

    // A done arriving on the expiry edge takes precedence over the timeout.
    assign tmo_hit = (state_q == S_WAIT) && !i_pc_done && (tmo_q == TMO_LAST);

    // Counter restarts at zero on every entry to s_wait.
    always_comb begin
        tmo_d = '0;
        if (state_q == S_WAIT) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cap_d   = cap_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_pc_done) begin
                    cap_d   = {i_v, i_beta, i_alpha};
                    idx_d   = '0;
                    state_d = S_STREAM;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_STREAM: begin
                if (i_data_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cap_q   <= cap_d;
        end
    end

    assign o_busy       = (state_q != S_IDLE);
    assign o_pc_start   = (state_q == S_REQ);
    assign o_done       = (state_q == S_FIN);
    assign o_timeout    = tmo_hit;
    assign o_data_valid = (state_q == S_STREAM);
    // Word is forced to zero outside streaming so idle/reset outputs are all 0.
    assign o_data       = o_data_valid ? cap_q[32*int'(idx_q) +: 32] : 32'h0;

endmodule

// File: tb/tb_pc_result_serializer.sv
// tb/tb_pc_result_serializer.sv - scoreboard bench for pc_result_serializer (T=3 and T=4 instances)

module tb_pc_result_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b0;
    always #5 clk = ~clk;

    // T=3 instance
    logic         start3 = 1'b0, pcd3 = 1'b0;
    logic [95:0]  alpha3 = '0, beta3 = '0, vv3 = '0;
    logic         busy3, done3, to3, ps3, dv3;
    logic [31:0]  d3;

    // T=4 instance
    logic         start5 = 1'b0, pcd5 = 1'b0;
    logic [127:0] alpha5 = '0, beta5 = '0, vv5 = '0;
    logic         busy5, done5, to5, ps5, dv5;
    logic [31:0]  d5;

    pc_result_serializer #(.PARAMETER_SET("L1"), .TIMEOUT_CYCLES(100)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_start(start3), .o_busy(busy3), .o_done(done3),
        .o_timeout(to3), .o_pc_start(ps3), .i_pc_done(pcd3), .i_alpha(alpha3),
        .i_beta(beta3), .i_v(vv3), .o_data(d3), .o_data_valid(dv3), .i_data_ready(rdy)
    );

    pc_result_serializer #(.PARAMETER_SET("L5"), .TIMEOUT_CYCLES(100)) dut5 (
        .i_clk(clk), .i_rst(rst), .i_start(start5), .o_busy(busy5), .o_done(done5),
        .o_timeout(to5), .o_pc_start(ps5), .i_pc_done(pcd5), .i_alpha(alpha5),
        .i_beta(beta5), .i_v(vv5), .o_data(d5), .o_data_valid(dv5), .i_data_ready(rdy)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] q3[$];
    logic [31:0] q5[$];
    int          pcs3 = 0, pcs5 = 0;
    logic        hold3 = 1'b0, hold5 = 1'b0;
    logic [31:0] held3 = '0, held5 = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitors: pop expected word on each transfer, verify stability under backpressure.
    always @(negedge clk) begin
        if (ps3) pcs3++;
        if (rst || !dv3) begin
            hold3 = 1'b0;
        end else begin
            if (hold3) check("hold3", d3, held3);
            if (rdy) begin
                if (q3.size() == 0) check("unexpected_word3", d3, 32'hxxxxxxxx);
                else check("word3", d3, q3.pop_front());
                hold3 = 1'b0;
            end else begin
                hold3 = 1'b1;
                held3 = d3;
            end
        end
    end

    always @(negedge clk) begin
        if (ps5) pcs5++;
        if (rst || !dv5) begin
            hold5 = 1'b0;
        end else begin
            if (hold5) check("hold5", d5, held5);
            if (rdy) begin
                if (q5.size() == 0) check("unexpected_word5", d5, 32'hxxxxxxxx);
                else check("word5", d5, q5.pop_front());
                hold5 = 1'b0;
            end else begin
                hold5 = 1'b1;
                held5 = d5;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_basic;
        alpha3 = {32'h33333333, 32'h22222222, 32'h11111111};
        beta3  = {32'h66666666, 32'h55555555, 32'h44444444};
        vv3    = {32'h99999999, 32'h88888888, 32'h77777777};
        for (int k = 1; k <= 9; k++) q3.push_back(32'h11111111 * k);
    endtask

    // Start request, check the start pulse, then deliver PC done after gap cycles.
    task automatic launch3(input int gap);
        start3 = 1'b1;
        tick;
        start3 = 1'b0;
        check("pc_start_hi", ps3, 1);
        check("busy_hi", busy3, 1);
        tick;
        check("pc_start_lo", ps3, 0);
        repeat (gap) tick;
        pcd3 = 1'b1;
        tick;
        pcd3 = 1'b0;
        // Inputs change after capture must not reach the stream.
        alpha3 = {3{32'hDEADBEEF}};
        beta3  = {3{32'hDEADBEEF}};
        vv3    = {3{32'hDEADBEEF}};
    endtask

    // Drive ready until o_done; returns cycles consumed.
    task automatic stream3(input bit bp, input bit spur, output int n);
        logic [3:0] pat;
        pat = 4'b1001;
        n = 0;
        while (!done3 && n < 200) begin
            rdy    = bp ? pat[3 - (n % 4)] : 1'b1;
            start3 = (spur && n == 3);
            tick;
            n++;
        end
        start3 = 1'b0;
        rdy    = 1'b0;
        if (n >= 200) check("stream3_bound", 0, 1);
        check("done_pulse", done3, 1);
        check("valid_in_fin", dv3, 0);
        tick;
        check("done_lo", done3, 0);
        check("busy_lo", busy3, 0);
        check("queue3_empty", q3.size(), 0);
    endtask

    initial begin
        int n;
        int pexp;
        logic saw_v;

        // Reset state
        rst = 1'b1;
        tick; tick;
        check("rst_busy", busy3, 0);
        check("rst_done", done3, 0);
        check("rst_timeout", to3, 0);
        check("rst_pc_start", ps3, 0);
        check("rst_valid", dv3, 0);
        check("rst_data", d3, 0);
        check("rst_valid5", dv5, 0);
        rst = 1'b0;
        tick;

        // Basic: done 50 cycles after start pulse, ready always high
        load_basic;
        launch3(48);
        check("valid_after_done", dv3, 1);
        stream3(1'b0, 1'b0, n);
        check("basic_cycles", n, 9);

        // Spurious done in idle, then backpressure with spurious start mid-stream
        pcd3 = 1'b1;
        tick;
        pcd3 = 1'b0;
        check("idle_ignores_done", busy3, 0);
        pexp = pcs3 + 1;
        load_basic;
        launch3(5);
        stream3(1'b1, 1'b1, n);
        check("bp_cycles", n, 17);
        check("pc_start_count", pcs3, pexp);

        // Reset mid-stream after four words accepted
        load_basic;
        launch3(3);
        rdy = 1'b1;
        repeat (4) tick;
        rdy = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("mrst_busy", busy3, 0);
        check("mrst_valid", dv3, 0);
        check("mrst_data", d3, 0);
        check("mrst_done", done3, 0);
        check("mrst_remaining", q3.size(), 5);
        q3.delete();
        load_basic;
        launch3(2);
        stream3(1'b0, 1'b0, n);
        check("restart_cycles", n, 9);

        // L5: T=4, twelve words
        for (int k = 0; k < 4; k++) begin
            alpha5[32*k +: 32] = 32'h0A000000 + k;
            beta5[32*k +: 32]  = 32'h0B000000 + k;
            vv5[32*k +: 32]    = 32'h0C000000 + k;
        end
        for (int k = 0; k < 4; k++) q5.push_back(32'h0A000000 + k);
        for (int k = 0; k < 4; k++) q5.push_back(32'h0B000000 + k);
        for (int k = 0; k < 4; k++) q5.push_back(32'h0C000000 + k);
        start5 = 1'b1;
        tick;
        start5 = 1'b0;
        check("l5_pc_start", ps5, 1);
        repeat (10) tick;
        pcd5 = 1'b1;
        tick;
        pcd5 = 1'b0;
        n = 0;
        rdy = 1'b1;
        while (!done5 && n < 200) begin
            tick;
            n++;
        end
        rdy = 1'b0;
        check("l5_cycles", n, 12);
        check("l5_done", done5, 1);
        check("l5_queue_empty", q5.size(), 0);
        check("l5_pc_start_count", pcs5, 1);
        tick;
        check("l5_busy_lo", busy5, 0);

`ifdef PC_TIMEOUT_EN
        // Timeout with no PC done
        start3 = 1'b1;
        tick;
        start3 = 1'b0;
        tick;
        n = 1;
        saw_v = 1'b0;
        while (!to3 && n < 300) begin
            if (dv3) saw_v = 1'b1;
            tick;
            n++;
        end
        check("tmo_cycles", n, 100);
        check("tmo_no_valid", saw_v, 0);
        tick;
        check("tmo_pulse_lo", to3, 0);
        check("tmo_busy_lo", busy3, 0);
        check("tmo_valid_lo", dv3, 0);

        // Done on the expiry edge wins
        load_basic;
        start3 = 1'b1;
        tick;
        start3 = 1'b0;
        tick;
        repeat (99) tick;
        pcd3 = 1'b1;
        #1;
        check("tmo_done_wins", to3, 0);
        tick;
        pcd3 = 1'b0;
        check("tmo_stream_valid", dv3, 1);
        stream3(1'b0, 1'b0, n);
        check("tmo_stream_cycles", n, 9);
`else
        check("timeout_tied_lo", to3, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
